seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_hex_decoder.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the seven-segment scan
//                controller: scan FSM states, register offsets, CTRL bit
//                positions and the all-off segment pattern.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LIT  = 2'd1,
        ST_GAP  = 2'd2
    } seg_state_t;

    // Register byte offsets from the block base address
    localparam logic [31:0] c_off_data = 32'h0000_0000;
    localparam logic [31:0] c_off_ctrl = 32'h0000_0004;
    localparam logic [31:0] c_off_div  = 32'h0000_0008;

    // CTRL register bit positions
    localparam int c_ctrl_en_bit   = 0;
    localparam int c_ctrl_lzs_bit  = 1;
    localparam int c_ctrl_mask_lsb = 8;

    // Active-low outputs: all ones turns everything off
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] c_dig_off = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_decoder
//  Description : Combinational hex nibble to active-low seven-segment pattern
//                ordered {A,B,C,D,E,F,G,DP}; the decimal point stays off.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg_n
);

    // Glyph lookup for 0-9, A, b, C, d, E, F
    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = 8'b0000_0011;
            4'h1: seg_n = 8'b1001_1111;
            4'h2: seg_n = 8'b0010_0101;
            4'h3: seg_n = 8'b0000_1101;
            4'h4: seg_n = 8'b1001_1001;
            4'h5: seg_n = 8'b0100_1001;
            4'h6: seg_n = 8'b0100_0001;
            4'h7: seg_n = 8'b0001_1111;
            4'h8: seg_n = 8'b0000_0001;
            4'h9: seg_n = 8'b0001_1001;
            4'hA: seg_n = 8'b0001_0001;
            4'hB: seg_n = 8'b1100_0001;
            4'hC: seg_n = 8'b0110_0011;
            4'hD: seg_n = 8'b1000_0101;
            4'hE: seg_n = 8'b0110_0001;
            4'hF: seg_n = 8'b0111_0001;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Memory-mapped 8-digit multiplexed seven-segment controller.
//                CPU-visible DATA/CTRL/DIV registers, double-buffered display
//                data, and a scan FSM with programmable dwell and a blank gap
//                between digits to avoid ghosting.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000,
    parameter int unsigned DIV_RESET  = 19_999,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg_n
);

    localparam logic [17:0] c_gap_last = 18'(GAP_CYCLES - 1);

    // CPU-visible registers
    logic [31:0] r_data_pend;
    logic        r_en;
    logic        r_lzs;
    logic [7:0]  r_mask;
    logic [17:0] r_div;

    // Display-side copy and scan state
    logic [31:0] r_data_act;
    seg_state_t  r_state;
    logic [17:0] r_cnt;
    logic [2:0]  r_cur;

    logic        w_sel_data;
    logic        w_sel_ctrl;
    logic        w_sel_div;
    logic [7:0]  w_keep;
    logic [7:0]  w_elig;
    logic        w_any;
    logic [2:0]  w_lo;
    logic [2:0]  w_above;
    logic        w_has_above;
    logic [2:0]  w_next;
    logic        w_run;
    logic        w_gap_done;
    logic        w_copy;
    logic [31:0] w_act_next;
    logic [2:0]  w_enter_idx;
    logic [3:0]  w_enter_nib;
    logic [7:0]  w_enter_seg;

    assign w_sel_data = (addr == (BASE_ADDR + c_off_data));
    assign w_sel_ctrl = (addr == (BASE_ADDR + c_off_ctrl));
    assign w_sel_div  = (addr == (BASE_ADDR + c_off_div));

    // Register file writes from the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_pend <= '0;
            r_en        <= 1'b1;
            r_lzs       <= 1'b0;
            r_mask      <= 8'hFF;
            r_div       <= 18'(DIV_RESET);
        end else if (wen) begin
            if (w_sel_data) begin
                r_data_pend <= wdata;
            end
            if (w_sel_ctrl) begin
                r_en   <= wdata[c_ctrl_en_bit];
                r_lzs  <= wdata[c_ctrl_lzs_bit];
                r_mask <= wdata[c_ctrl_mask_lsb +: 8];
            end
            if (w_sel_div) begin
                r_div <= wdata[17:0];
            end
        end
    end

    // Combinational readback; unmapped addresses and unused bits read zero
    always_comb begin
        rdata = '0;
        if (w_sel_data) begin
            rdata = r_data_pend;
        end else if (w_sel_ctrl) begin
            rdata[c_ctrl_en_bit]          = r_en;
            rdata[c_ctrl_lzs_bit]         = r_lzs;
            rdata[c_ctrl_mask_lsb +: 8]   = r_mask;
        end else if (w_sel_div) begin
            rdata[17:0] = r_div;
        end
    end

    // Leading-zero suppression keeps digits up to the top nonzero nibble;
    // digit 0 is always kept so a zero value still shows "0"
    always_comb begin
        w_keep = 8'h01;
        for (int i = 1; i < 8; i++) begin
            if (r_data_act[4*i +: 4] != 4'h0) begin
                w_keep = 8'hFF >> (7 - i);
            end
        end
    end

    assign w_elig = r_mask & (r_lzs ? w_keep : 8'hFF);
    assign w_any  = |w_elig;

    // Lowest eligible digit and the first eligible digit above the current one
    always_comb begin
        w_lo        = 3'd0;
        w_above     = 3'd0;
        w_has_above = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo = 3'(i);
                if (3'(i) > r_cur) begin
                    w_above     = 3'(i);
                    w_has_above = 1'b1;
                end
            end
        end
    end

    assign w_next = w_has_above ? w_above : w_lo;

    // Scanning is allowed only with the block enabled and some digit unmasked
    assign w_run      = r_en && (r_mask != 8'h00);
    assign w_gap_done = (r_state == ST_GAP) && (r_cnt == c_gap_last);

    // Pending data becomes active while idle and on every frame wrap, so a
    // frame is always drawn from one consistent snapshot
    assign w_copy = (r_state == ST_IDLE) ||
                    (w_gap_done && w_run && w_any && !w_has_above);

    assign w_act_next  = w_copy ? r_data_pend : r_data_act;
    assign w_enter_idx = (r_state == ST_GAP) ? w_next : w_lo;
    assign w_enter_nib = w_act_next[{w_enter_idx, 2'b00} +: 4];

    seg_hex_decoder u_dec (
        .nibble (w_enter_nib),
        .seg_n  (w_enter_seg)
    );

    // Active display snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_act <= '0;
        end else if (w_copy) begin
            r_data_act <= r_data_pend;
        end
    end

    // Scan FSM; outputs are loaded on state entry so they track the state flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
            dig_en  <= c_dig_off;
            seg_n   <= SEG_BLANK;
        end else if (!w_run) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
            dig_en  <= c_dig_off;
            seg_n   <= SEG_BLANK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_LIT;
                        r_cur   <= w_lo;
                        r_cnt   <= '0;
                        dig_en  <= ~(8'd1 << w_lo);
                        seg_n   <= w_enter_seg;
                    end
                end
                ST_LIT: begin
                    // >= so a DIV lowered below the running count ends the slot at once
                    if (r_cnt >= r_div) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        dig_en  <= c_dig_off;
                        seg_n   <= SEG_BLANK;
                    end else begin
                        r_cnt <= r_cnt + 18'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt <= '0;
                        if (w_any) begin
                            r_state <= ST_LIT;
                            r_cur   <= w_next;
                            dig_en  <= ~(8'd1 << w_next);
                            seg_n   <= w_enter_seg;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cur   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 18'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_cur   <= '0;
                    dig_en  <= c_dig_off;
                    seg_n   <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Directed self-checking bench for seg_scan_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam logic [31:0] A_DATA = 32'hFFFF_F000;
    localparam logic [31:0] A_CTRL = 32'hFFFF_F004;
    localparam logic [31:0] A_DIV  = 32'hFFFF_F008;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [31:0] addr  = '0;
    logic        wen   = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  dig_en;
    logic [7:0]  seg_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] seg_tbl [16];

    seg_scan_ctrl #(
        .BASE_ADDR  (32'hFFFF_F000),
        .DIV_RESET  (19_999),
        .GAP_CYCLES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wen    (wen),
        .wdata  (wdata),
        .rdata  (rdata),
        .dig_en (dig_en),
        .seg_n  (seg_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        step();
        wen   = 1'b0;
    endtask

    // Advance until dig_en newly takes the value val, within budget cycles
    task automatic wait_rise(input logic [7:0] val, input int budget, output bit ok);
        logic [7:0] prev;
        prev = dig_en;
        ok   = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (dig_en == val && prev != val) begin
                ok = 1'b1;
                break;
            end
            prev = dig_en;
        end
    endtask

    function automatic int lit_idx(input logic [7:0] d);
        int r;
        r = 0;
        for (int j = 7; j >= 0; j--) begin
            if (!d[j]) r = j;
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [7:0] ed;
        logic [7:0] es;
        int slot;
        int ph;
        #1 rst = 1'b1;
        step();
        checks++; if (dig_en !== 8'hFF) begin failures++; $display("FAIL reset_dig_en got=%h exp=%h", dig_en, 8'hFF); end
        checks++; if (seg_n !== 8'hFF) begin failures++; $display("FAIL reset_seg_n got=%h exp=%h", seg_n, 8'hFF); end
        addr = A_DATA; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", rdata, 32'h0); end
        addr = A_CTRL; #1;
        checks++; if (rdata !== 32'h0000_FF01) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", rdata, 32'h0000_FF01); end
        addr = A_DIV; #1;
        checks++; if (rdata !== 32'd19_999) begin failures++; $display("FAIL reset_div got=%h exp=%h", rdata, 32'd19_999); end
        @(posedge clk); #1;
        rst = 1'b0;
        // DIV lands on the same edge the FSM leaves IDLE for digit 0
        bus_write(A_DIV, 32'd3);
        checks++; if (rdata !== 32'd3) begin failures++; $display("FAIL div_readback got=%h exp=%h", rdata, 32'd3); end
        for (int k = 0; k < 50; k++) begin
            slot = k / 6;
            ph   = k % 6;
            ed   = (ph < 4) ? ~(8'd1 << (slot % 8)) : 8'hFF;
            es   = (ph < 4) ? 8'b0000_0011 : 8'hFF;
            checks++; if (dig_en !== ed) begin failures++; $display("FAIL scan_dig_en k=%0d got=%h exp=%h", k, dig_en, ed); end
            checks++; if (seg_n !== es) begin failures++; $display("FAIL scan_seg_n k=%0d got=%h exp=%h", k, seg_n, es); end
            step();
        end
    endtask

    task automatic test_tear();
        bit ok;
        bit new_frame;
        bit saw7;
        int d;
        logic [31:0] dv;
        logic [7:0] es;
        dv = 32'h1234_5678;
        wait_rise(8'hF7, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tear_sync got=timeout exp=digit3"); end
        bus_write(A_DATA, dv);
        checks++; if (rdata !== dv) begin failures++; $display("FAIL tear_readback got=%h exp=%h", rdata, dv); end
        new_frame = 1'b0;
        saw7      = 1'b0;
        for (int k = 0; k < 110; k++) begin
            if (dig_en != 8'hFF) begin
                d = lit_idx(dig_en);
                if (d == 0) new_frame = 1'b1;
                es = new_frame ? seg_tbl[dv[4*d +: 4]] : 8'b0000_0011;
                if (new_frame && d == 7) saw7 = 1'b1;
                checks++; if (seg_n !== es) begin failures++; $display("FAIL tear_seg d=%0d new=%0d got=%h exp=%h", d, new_frame, seg_n, es); end
            end
            step();
        end
        checks++; if (!saw7) begin failures++; $display("FAIL tear_frame got=%0d exp=1", saw7); end
    endtask

    task automatic test_mask();
        bit ok;
        logic [7:0] ed;
        logic [7:0] es;
        int slot;
        int ph;
        bus_write(A_DIV, 32'd1);
        bus_write(A_CTRL, 32'h0000_0501);
        wait_rise(8'hFE, 80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mask_sync got=timeout exp=FE"); end
        for (int k = 0; k < 16; k++) begin
            slot = k / 4;
            ph   = k % 4;
            ed   = (ph >= 2) ? 8'hFF : ((slot % 2 == 0) ? 8'hFE : 8'hFB);
            es   = (ph >= 2) ? 8'hFF : ((slot % 2 == 0) ? 8'b0000_0001 : 8'b0100_0001);
            checks++; if (dig_en !== ed) begin failures++; $display("FAIL mask_dig_en k=%0d got=%h exp=%h", k, dig_en, ed); end
            checks++; if (seg_n !== es) begin failures++; $display("FAIL mask_seg_n k=%0d got=%h exp=%h", k, seg_n, es); end
            step();
        end
    endtask

    task automatic test_lzs();
        bit ok;
        logic [7:0] ed;
        logic [7:0] es;
        int slot;
        int ph;
        bus_write(A_DATA, 32'h0000_00A0);
        bus_write(A_CTRL, 32'h0000_FF03);
        wait_rise(8'hFE, 80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lzs_sync got=timeout exp=FE"); end
        for (int k = 0; k < 16; k++) begin
            slot = k / 4;
            ph   = k % 4;
            ed   = (ph >= 2) ? 8'hFF : ((slot % 2 == 0) ? 8'hFE : 8'hFD);
            es   = (ph >= 2) ? 8'hFF : ((slot % 2 == 0) ? 8'b0000_0011 : 8'b0001_0001);
            checks++; if (dig_en !== ed) begin failures++; $display("FAIL lzs_dig_en k=%0d got=%h exp=%h", k, dig_en, ed); end
            checks++; if (seg_n !== es) begin failures++; $display("FAIL lzs_seg_n k=%0d got=%h exp=%h", k, seg_n, es); end
            step();
        end
        bus_write(A_DATA, 32'h0);
        wait_rise(8'hFE, 80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lzs0_sync got=timeout exp=FE"); end
        for (int k = 0; k < 12; k++) begin
            ed = ((k % 4) < 2) ? 8'hFE : 8'hFF;
            checks++; if (dig_en !== ed) begin failures++; $display("FAIL lzs0_dig_en k=%0d got=%h exp=%h", k, dig_en, ed); end
            step();
        end
    endtask

    task automatic test_div_change();
        bit ok;
        logic [7:0] ed;
        int j;
        bus_write(A_CTRL, 32'h0000_FF01);
        bus_write(A_DIV, 32'd10);
        wait_rise(8'hFE, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL div_sync got=timeout exp=FE"); end
        repeat (6) step();
        // lands on the edge where the slot count is 6
        bus_write(A_DIV, 32'd2);
        for (int k = 0; k < 21; k++) begin
            if (k == 0) begin
                ed = 8'hFE;
            end else begin
                j  = k - 1;
                ed = ((j % 5) < 2) ? 8'hFF : ~(8'd1 << ((j / 5 + 1) % 8));
            end
            checks++; if (dig_en !== ed) begin failures++; $display("FAIL div_dig_en k=%0d got=%h exp=%h", k, dig_en, ed); end
            step();
        end
    endtask

    task automatic test_disable();
        bit ok;
        wait_rise(8'hFD, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dis_sync got=timeout exp=FD"); end
        bus_write(A_CTRL, 32'h0000_FF00);
        checks++; if (dig_en !== 8'hFD) begin failures++; $display("FAIL dis_hold got=%h exp=%h", dig_en, 8'hFD); end
        step();
        checks++; if (dig_en !== 8'hFF) begin failures++; $display("FAIL dis_dig_en got=%h exp=%h", dig_en, 8'hFF); end
        checks++; if (seg_n !== 8'hFF) begin failures++; $display("FAIL dis_seg_n got=%h exp=%h", seg_n, 8'hFF); end
        bus_write(A_DATA, 32'h0000_00C5);
        bus_write(A_CTRL, 32'h0000_FF01);
        checks++; if (dig_en !== 8'hFF) begin failures++; $display("FAIL idle_dig_en got=%h exp=%h", dig_en, 8'hFF); end
        step();
        checks++; if (dig_en !== 8'hFE) begin failures++; $display("FAIL reen_dig_en got=%h exp=%h", dig_en, 8'hFE); end
        checks++; if (seg_n !== 8'b0100_1001) begin failures++; $display("FAIL reen_seg_n got=%h exp=%h", seg_n, 8'b0100_1001); end
        repeat (5) step();
        checks++; if (dig_en !== 8'hFD) begin failures++; $display("FAIL reen_d1 got=%h exp=%h", dig_en, 8'hFD); end
        checks++; if (seg_n !== 8'b0110_0011) begin failures++; $display("FAIL reen_d1_seg got=%h exp=%h", seg_n, 8'b0110_0011); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_rise(8'hFF, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstgap_sync got=timeout exp=FF"); end
        #3 rst = 1'b1;
        #1;
        checks++; if (dig_en !== 8'hFF) begin failures++; $display("FAIL rstgap_dig_en got=%h exp=%h", dig_en, 8'hFF); end
        checks++; if (seg_n !== 8'hFF) begin failures++; $display("FAIL rstgap_seg_n got=%h exp=%h", seg_n, 8'hFF); end
        addr = A_DIV; #1;
        checks++; if (rdata !== 32'd19_999) begin failures++; $display("FAIL rstgap_div got=%h exp=%h", rdata, 32'd19_999); end
        addr = A_DATA; #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstgap_data got=%h exp=%h", rdata, 32'h0); end
        addr = A_CTRL; #1;
        checks++; if (rdata !== 32'h0000_FF01) begin failures++; $display("FAIL rstgap_ctrl got=%h exp=%h", rdata, 32'h0000_FF01); end
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        checks++; if (dig_en !== 8'hFE) begin failures++; $display("FAIL rstlit_pre got=%h exp=%h", dig_en, 8'hFE); end
        #3 rst = 1'b1;
        #1;
        checks++; if (dig_en !== 8'hFF) begin failures++; $display("FAIL rstlit_dig_en got=%h exp=%h", dig_en, 8'hFF); end
        checks++; if (seg_n !== 8'hFF) begin failures++; $display("FAIL rstlit_seg_n got=%h exp=%h", seg_n, 8'hFF); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        seg_tbl = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                    8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
                    8'b0000_0001, 8'b0001_1001, 8'b0001_0001, 8'b1100_0001,
                    8'b0110_0011, 8'b1000_0101, 8'b0110_0001, 8'b0111_0001};
        test_reset();
        test_tear();
        test_mask();
        test_lzs();
        test_div_change();
        test_disable();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
